// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 game controller: FSM states,
// direction encoding and board geometry.
package game2048_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_READY = 3'd2,
        ST_MOVE  = 3'd3,
        ST_CHECK = 3'd4,
        ST_WON   = 3'd5,
        ST_LOST  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int CELL_W     = 12;
    localparam int MAX_WIN    = 11;
    localparam int INIT_TILES = 2;

endpackage

// File: rtl/game_ctrl_dir_encoder.sv
// One-hot {up,down,left,right} to 2-bit direction code; valid only when
// exactly one bit is set.
module dir_encoder
    import game2048_pkg::*;
(
    input  logic [3:0] onehot,
    output logic [1:0] code,
    output logic       valid
);

    always_comb begin
        code  = DIR_UP;
        valid = 1'b0;
        case (onehot)
            4'b1000: begin code = DIR_UP;    valid = 1'b1; end
            4'b0100: begin code = DIR_DOWN;  valid = 1'b1; end
            4'b0010: begin code = DIR_LEFT;  valid = 1'b1; end
            4'b0001: begin code = DIR_RIGHT; valid = 1'b1; end
            default: begin code = DIR_UP;    valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/game_ctrl.sv
// 2048 game sequencing FSM with spawn/move watchdog.
// Optional move counter enabled by defining GAME_CTRL_MOVE_CNT_EN.
module game_ctrl
    import game2048_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir_valid,
    input  logic [3:0]       dir_in,
    input  logic             move_done,
    input  logic             move_changed,
    input  logic             spawn_done,
    input  logic             win_in,
    input  logic             lose_in,
    output logic             board_clr,
    output logic             move_req,
    output logic [1:0]       move_dir,
    output logic             spawn_req,
    output logic             busy,
    output logic             game_won,
    output logic             game_over,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] move_count
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t          st;
    logic [1:0]      init_cnt;
    logic [WD_W-1:0] wd;
    logic [1:0]      enc_code;
    logic            enc_valid;
    logic            wd_expired;
    logic            restart;

    dir_encoder u_enc (
        .onehot (dir_in),
        .code   (enc_code),
        .valid  (enc_valid)
    );

    assign state      = st;
    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
    assign restart    = start && (st == ST_IDLE || st == ST_WON ||
                                  st == ST_LOST || st == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            init_cnt  <= 2'd0;
            wd        <= '0;
            board_clr <= 1'b0;
            move_req  <= 1'b0;
            move_dir  <= 2'b00;
            spawn_req <= 1'b0;
            busy      <= 1'b0;
            game_won  <= 1'b0;
            game_over <= 1'b0;
            error     <= 1'b0;
        end else begin
            board_clr <= 1'b0;
            move_req  <= 1'b0;
            spawn_req <= 1'b0;
            case (st)
                ST_IDLE, ST_WON, ST_LOST, ST_ERR: begin
                    if (restart) begin
                        st        <= ST_SPAWN;
                        board_clr <= 1'b1;
                        spawn_req <= 1'b1;
                        init_cnt  <= 2'(INIT_TILES);
                        wd        <= '0;
                        busy      <= 1'b1;
                        game_won  <= 1'b0;
                        game_over <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                ST_SPAWN: begin
                    if (spawn_done) begin
                        // Initial board needs two tiles; after a move only one.
                        if (init_cnt > 2'd1) begin
                            init_cnt  <= init_cnt - 2'd1;
                            spawn_req <= 1'b1;
                            wd        <= '0;
                        end else begin
                            st <= ST_CHECK;
                        end
                    end else if (wd_expired) begin
                        st    <= ST_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_READY: begin
                    if (dir_valid && enc_valid) begin
                        st       <= ST_MOVE;
                        move_dir <= enc_code;
                        move_req <= 1'b1;
                        wd       <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (move_done) begin
                        if (move_changed) begin
                            st        <= ST_SPAWN;
                            spawn_req <= 1'b1;
                            init_cnt  <= 2'd1;
                            wd        <= '0;
                        end else begin
                            st   <= ST_READY;
                            busy <= 1'b0;
                        end
                    end else if (wd_expired) begin
                        st    <= ST_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (win_in) begin
                        st       <= ST_WON;
                        game_won <= 1'b1;
                    end else if (lose_in) begin
                        st        <= ST_LOST;
                        game_over <= 1'b1;
                    end else begin
                        st <= ST_READY;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

`ifdef GAME_CTRL_MOVE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (st == ST_MOVE && move_done && move_changed && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign move_count = cnt_q;
`else
    assign move_count = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized scoreboard bench for game_ctrl: driver tasks push expected
// request pulses, a negedge monitor pops and compares them.
module tb_game_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 255;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // State codes in the order the states are listed.
    localparam logic [2:0] S_IDLE = 3'd0, S_SPAWN = 3'd1, S_READY = 3'd2, S_MOVE = 3'd3,
                           S_CHECK = 3'd4, S_WON = 3'd5, S_LOST = 3'd6, S_ERR = 3'd7;

    // Expected pulse events: {kind, dir}
    localparam logic [3:0] EV_CLR = 4'b0100, EV_SPAWN = 4'b1000;

    logic clk = 1'b0;
    logic rst_n, start, dir_valid, move_done, move_changed, spawn_done, win_in, lose_in;
    logic [3:0] dir_in;
    logic board_clr, move_req, spawn_req, busy, game_won, game_over, error;
    logic [1:0] move_dir;
    logic [2:0] state;
    logic [CNT_W-1:0] move_count;

    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int model_cnt = 0;
    logic [2:0] model_state = S_IDLE;

    game_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir_valid(dir_valid), .dir_in(dir_in),
        .move_done(move_done), .move_changed(move_changed), .spawn_done(spawn_done),
        .win_in(win_in), .lose_in(lose_in), .board_clr(board_clr), .move_req(move_req),
        .move_dir(move_dir), .spawn_req(spawn_req), .busy(busy), .game_won(game_won),
        .game_over(game_over), .error(error), .state(state), .move_count(move_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int exp_cnt();
`ifdef GAME_CTRL_MOVE_CNT_EN
        return (model_cnt > CNT_MAX) ? CNT_MAX : model_cnt;
`else
        return 0;
`endif
    endfunction

    // Direction code from one-hot {up,down,left,right}: up=0 ... right=3.
    function automatic logic [1:0] dir_code(input logic [3:0] oh);
        logic [1:0] c = 2'b00;
        for (int i = 0; i < 4; i++) if (oh[i]) c = 2'(3 - i);
        return c;
    endfunction

    // scoreboard monitor
    task automatic pop_cmp(input string name, input logic [3:0] act);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected pulse %0h, expected none", name, act);
        end else begin
            logic [3:0] e = exp_q.pop_front();
            if (act === e) n_pass++;
            else $display("FAIL %s: got event %0h expected %0h", name, act, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (board_clr) pop_cmp("board_clr", EV_CLR);
            if (spawn_req) pop_cmp("spawn_req", EV_SPAWN);
            if (move_req)  pop_cmp("move_req", {2'b11, move_dir});
        end
    end

    // driver tasks
    task automatic noise(input int where);
        start     = (where != 0) && ($urandom_range(0, 2) == 0);
        dir_valid = (where != 0) && ($urandom_range(0, 1) == 0);
        dir_in    = 4'($urandom_range(0, 15));
        move_done = (where == 1) && ($urandom_range(0, 2) == 0);
        move_changed = 1'($urandom_range(0, 1));
        spawn_done = (where == 2) && ($urandom_range(0, 2) == 0);
    endtask

    task automatic answer_spawn(input logic win, input logic lose);
        int k;
        for (k = 0; k < 50; k++) begin
            if (spawn_req) break;
            @(negedge clk);
        end
        if (k == 50) begin
            chk("spawn_req_wait", 0, 1);
            return;
        end
        repeat ($urandom_range(0, 4)) begin
            noise(1);
            @(negedge clk);
        end
        noise(0);
        spawn_done = 1'b1;
        win_in = win;
        lose_in = lose;
        @(negedge clk);
        spawn_done = 1'b0;
    endtask

    task automatic check_outcome(input logic win, input logic lose);
        @(negedge clk);
        model_state = win ? S_WON : (lose ? S_LOST : S_READY);
        chk("state", state, model_state);
        chk("game_won", game_won, model_state == S_WON);
        chk("game_over", game_over, model_state == S_LOST);
        chk("error", error, 0);
        chk("busy", busy, 0);
        chk("move_count", move_count, exp_cnt());
        win_in = 1'b0;
        lose_in = 1'b0;
    endtask

    task automatic do_start(input logic win, input logic lose);
        exp_q.push_back(EV_CLR);
        exp_q.push_back(EV_SPAWN);
        model_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        answer_spawn(1'b0, 1'b0);
        exp_q.push_back(EV_SPAWN);
        answer_spawn(win, lose);
        check_outcome(win, lose);
    endtask

    task automatic do_move(input logic [3:0] oh, input logic changed, input logic win, input logic lose);
        logic ok;
        ok = ($countones(oh) == 1);
        if (ok) exp_q.push_back({2'b11, dir_code(oh)});
        dir_valid = 1'b1;
        dir_in = oh;
        @(negedge clk);
        dir_valid = 1'b0;
        if (!ok) begin
            chk("bad_dir_state", state, S_READY);
            chk("bad_dir_busy", busy, 0);
            return;
        end
        chk("move_state", state, S_MOVE);
        chk("move_dir", move_dir, dir_code(oh));
        chk("move_busy", busy, 1);
        repeat ($urandom_range(0, 4)) begin
            noise(2);
            @(negedge clk);
        end
        noise(0);
        move_done = 1'b1;
        move_changed = changed;
        @(negedge clk);
        move_done = 1'b0;
        if (changed) begin
            model_cnt++;
            exp_q.push_back(EV_SPAWN);
            answer_spawn(win, lose);
            check_outcome(win, lose);
        end else begin
            chk("unchanged_state", state, S_READY);
            chk("unchanged_count", move_count, exp_cnt());
        end
    endtask

    task automatic rand_move();
        logic [3:0] oh;
        if ($urandom_range(0, 9) < 7) oh = 4'(1 << $urandom_range(0, 3));
        else oh = 4'($urandom_range(0, 15));
        do_move(oh, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_in = 4'b0; move_done = 1'b0;
        move_changed = 1'b0; spawn_done = 1'b0; win_in = 1'b0; lose_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {board_clr, move_req, spawn_req, busy, game_won, game_over,
                              error, state, move_dir, move_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // New game, first move, rejected directions, unchanged move.
        do_start(1'b0, 1'b0);
        do_move(4'b0010, 1'b1, 1'b0, 1'b0);
        do_move(4'b0011, 1'b1, 1'b0, 1'b0);
        do_move(4'b0000, 1'b1, 1'b0, 1'b0);
        do_move(4'b1000, 1'b0, 1'b0, 1'b0);

        // Stray done pulses in READY are ignored.
        move_done = 1'b1; move_changed = 1'b1; spawn_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0; spawn_done = 1'b0;
        @(negedge clk);
        chk("stray_done_state", state, S_READY);
        chk("stray_done_count", move_count, exp_cnt());

        // Random games.
        for (int g = 0; g < 6; g++) begin
            if (model_state != S_READY) do_start($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
            for (int m = 0; m < 20 && model_state == S_READY; m++) rand_move();
            if (model_state == S_READY) do_move(4'b0100, 1'b1, 1'b0, 1'b1);
        end

        // Win has priority over lose; restart clears the flag.
        do_start(1'b0, 1'b0);
        do_move(4'b0001, 1'b1, 1'b1, 1'b1);
        do_start(1'b0, 1'b0);

        // Saturation of the move counter.
        for (int m = 0; m < 17; m++) do_move(4'(1 << (m % 4)), 1'b1, 1'b0, 1'b0);
        chk("sat_count", move_count, exp_cnt());

        // Watchdog on a move that never completes.
        exp_q.push_back({2'b11, 2'b01});
        dir_valid = 1'b1; dir_in = 4'b0100;
        @(negedge clk);
        dir_valid = 1'b0;
        k = 0;
        while (state == S_MOVE && k < 400) begin
            k++;
            @(negedge clk);
        end
        chk("timeout_cycles", k, TIMEOUT);
        chk("timeout_state", state, S_ERR);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        model_state = S_ERR;

        // Restart from ERR, then asynchronous reset mid-move.
        do_start(1'b0, 1'b0);
        exp_q.push_back({2'b11, 2'b11});
        dir_valid = 1'b1; dir_in = 4'b0001;
        @(negedge clk);
        dir_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {board_clr, move_req, spawn_req, busy, game_won, game_over,
                                    error, state, move_dir, move_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_state", state, S_IDLE);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
